// File: rtl/risc16_mem_pkg.sv
// Shared definitions for the RISC16 data-memory responder: FSM state
// encoding, default wait-state count and the data returned on errors.
package risc16_mem_pkg;

  // Responder FSM states; 2'd3 is unreachable and is decoded as IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Default number of wait states between acceptance and response.
  localparam int WAIT_CYCLES_DEFAULT = 2;

  // Read data reported for stores and for erroneous accesses.
  localparam logic [15:0] RSP_ERR_DATA = 16'h0000;

endpackage

// File: rtl/data_mem_array.sv
// Word-organised data RAM: synchronous write, combinational read.
// Contents are deliberately not reset.
module data_mem_array #(
  parameter int DATA_W      = 16,
  parameter int DEPTH_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [DATA_W-1:0]              wdata,
  output logic [DATA_W-1:0]              rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Write the addressed word on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory port. Accepts one load/store at a
// time, waits a programmable number of cycles, commits the access to the
// word RAM and holds the response until the requester takes it.
module data_mem_responder
  import risc16_mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 8,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  mem_state_t        state;
  mem_state_t        state_next;
  logic [3:0]        cnt;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic              accept;
  logic              commit;
  logic              rsp_fire;
  logic              addr_err;
  logic [IDX_W-1:0]  idx;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign accept   = req_valid & req_ready;
  assign rsp_fire = rsp_valid & rsp_ready;

  // The access commits on the edge where the wait counter has run out,
  // so the response appears WAIT_CYCLES+1 edges after acceptance.
  assign commit   = (state == WAIT) && (cnt == 4'd0);

  assign idx      = lat_addr[IDX_W:1];
  assign addr_err = lat_addr[0] | (|lat_addr[ADDR_W-1:IDX_W+1]);
  assign mem_we   = commit & lat_write & ~addr_err;

  data_mem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (idx),
    .wdata (lat_wdata),
    .rdata (mem_rdata)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> WAIT on accept, WAIT -> RESP on commit,
  // RESP -> IDLE on the response handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept)   state_next = WAIT;
      WAIT: if (commit)   state_next = RESP;
      RESP: if (rsp_fire) state_next = IDLE;
      default:            state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    req_ready = 1'b1;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      WAIT: begin
        req_ready = 1'b0;
        busy      = 1'b1;
      end
      RESP: begin
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        req_ready = 1'b1;
      end
    endcase
  end

  // Capture the request at acceptance and run the wait counter, which
  // stops at zero instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      cnt       <= 4'(WAIT_CYCLES);
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response data: loaded at commit, held through backpressure, cleared
  // when the requester takes the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_rdata <= (addr_err | lat_write) ? DATA_W'(RSP_ERR_DATA) : mem_rdata;
      rsp_err   <= addr_err;
    end else if (rsp_fire) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule
